hist_eq_controller: RTL and testbench

Sequencer for the per-frame histogram-equalization pass. It owns a simple-dual-port histogram memory with synchronous read. The block clears the memory after reset, then accumulates one frame of 8-bit pixels using a forwarded read-modify-write pipeline. It then scans the 256 bins to build the cumulative distribution, emits a 256-entry 8-bit remap LUT, and zeroes each bin during the scan so the next frame starts clean.

---
 rtl/hist_eq_controller.sv | 250 +++++++++++++++++++++++++
 tb/tb_hist_eq_controller.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hist_eq_controller.sv
// hist_eq_controller
//
// Sequencer for a per-frame histogram-equalization pass. It owns an external
// simple-dual-port histogram memory with a one-cycle synchronous read.
//
// Flow:
//   1. INIT_CLR: after reset, every bin is written with zero.
//   2. IDLE: waits for a start pulse.
//   3. ACCUM: counts one frame of 8-bit pixels into the bins.
//   4. DRAIN: lets the final read-modify-write land.
//   5. SCAN: walks the 256 bins, accumulates the CDF and emits the remap LUT.
//      Each bin is zeroed as it is read, so the next frame starts clean.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high
//   start        one-cycle pulse, honoured only in IDLE
//   pix_valid    pixel qualifier
//   pix_data     pixel value (bin index)
//   pix_ready    high only while accumulating; transfer = pix_valid & pix_ready
//   mem_rd_addr  histogram read address (data returns next cycle)
//   mem_rdata    histogram read data
//   mem_we       histogram write enable
//   mem_wr_addr  histogram write address
//   mem_wdata    histogram write data
//   lut_we       LUT entry strobe
//   lut_addr     LUT index
//   lut_data     equalized output level
//   busy         high in every state except IDLE
//   done         one-cycle pulse once the LUT is complete

module hist_eq_controller #(
   parameter int LOG2_PIX = 16,
   parameter int BIN_W    = LOG2_PIX + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             pix_valid,
   input  logic [7:0]       pix_data,
   output logic             pix_ready,
   output logic [7:0]       mem_rd_addr,
   input  logic [BIN_W-1:0] mem_rdata,
   output logic             mem_we,
   output logic [7:0]       mem_wr_addr,
   output logic [BIN_W-1:0] mem_wdata,
   output logic             lut_we,
   output logic [7:0]       lut_addr,
   output logic [7:0]       lut_data,
   output logic             busy,
   output logic             done
);

   typedef enum logic [2:0] {
      INIT_CLR,
      IDLE,
      ACCUM,
      DRAIN,
      SCAN
   } state_t;

   // Index of the last pixel of a frame; the transfer that sees this count
   // is the one that completes the frame.
   localparam logic [LOG2_PIX:0] FRAME_LAST = (LOG2_PIX+1)'((1 << LOG2_PIX) - 1);
   localparam logic [BIN_W-1:0]  BIN_MAX    = {BIN_W{1'b1}};
   localparam logic [BIN_W+7:0]  LEVEL_MAX  = (BIN_W+8)'(255);

   state_t             state;

   // Power-up clear sequencer: counter runs 0..256, the registered write
   // strobe and address trail it by one cycle.
   logic [8:0]         clr_cnt;
   logic               clr_we;
   logic [7:0]         clr_addr;

   // Accumulation pipeline: S1 holds the pixel whose bin read is in flight.
   logic [LOG2_PIX:0]  pix_cnt;
   logic               s1_valid;
   logic [7:0]         s1_bin;

   // Copy of the previous accumulation write, used when the memory read
   // was issued in the same cycle that write was landing.
   logic               fwd_valid;
   logic [7:0]         fwd_bin;
   logic [BIN_W-1:0]   fwd_data;

   // Scan sequencer: scan_cnt issues reads 0..255 and a 257th cycle flushes
   // the last entry; scan_v/scan_addr mark the entry whose data is returning.
   logic [8:0]         scan_cnt;
   logic               scan_v;
   logic [7:0]         scan_addr;
   logic [BIN_W-1:0]   cdf;
   logic               done_r;

   logic               transfer;
   logic [BIN_W-1:0]   base;
   logic [BIN_W-1:0]   acc_wdata;
   logic [BIN_W-1:0]   cdf_next;
   logic [BIN_W+7:0]   prod;
   logic [BIN_W+7:0]   scaled;
   logic [7:0]         lut_level;

   assign transfer  = pix_valid && (state == ACCUM);
   assign pix_ready = (state == ACCUM);
   assign busy      = (state != IDLE);
   assign done      = done_r;

   // Read-modify-write datapath for the bin in S1. If the previous cycle
   // wrote the same bin, the memory read raced that write and returned the
   // stale value, so the registered previous write data is used instead.
   // The increment saturates so a bin never wraps to zero.
   always_comb begin
      base = mem_rdata;
      if (fwd_valid && (fwd_bin == s1_bin)) begin
         base = fwd_data;
      end
      acc_wdata = (base == BIN_MAX) ? base : base + 1'b1;
   end

   // CDF including the bin whose data is arriving this cycle, scaled by 255
   // (as shift-and-subtract) and normalised by the frame size. A complete
   // frame lands exactly on 255; the clamp only guards oversized counts.
   always_comb begin
      cdf_next  = cdf + mem_rdata;
      prod      = {cdf_next, 8'd0} - {8'd0, cdf_next};
      scaled    = prod >> LOG2_PIX;
      lut_level = (scaled > LEVEL_MAX) ? 8'hFF : scaled[7:0];
   end

   // Read address: the incoming pixel's bin while accumulating, otherwise
   // the scan index while the scan is still issuing reads.
   always_comb begin
      mem_rd_addr = 8'd0;
      if (transfer) begin
         mem_rd_addr = pix_data;
      end else if ((state == SCAN) && !scan_cnt[8]) begin
         mem_rd_addr = scan_cnt[7:0];
      end
   end

   // Write port arbitration. The clear, accumulate and scan writers are
   // active in disjoint phases, so at most one of them is ever enabled.
   always_comb begin
      mem_we      = clr_we || s1_valid || scan_v;
      mem_wr_addr = 8'd0;
      mem_wdata   = '0;
      if (clr_we) begin
         mem_wr_addr = clr_addr;
      end else if (s1_valid) begin
         mem_wr_addr = s1_bin;
         mem_wdata   = acc_wdata;
      end else if (scan_v) begin
         mem_wr_addr = scan_addr;
      end
   end

   // LUT output follows the scan pipeline stage directly.
   always_comb begin
      lut_we   = scan_v;
      lut_addr = scan_addr;
      lut_data = scan_v ? lut_level : 8'd0;
   end

   // Main sequencer plus the pipeline registers it steps.
   // Reset drops back into the memory clear, so a frame interrupted by reset
   // never leaves stale counts behind for the next one.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= INIT_CLR;
         clr_cnt   <= '0;
         clr_we    <= 1'b0;
         clr_addr  <= 8'd0;
         pix_cnt   <= '0;
         s1_valid  <= 1'b0;
         s1_bin    <= 8'd0;
         fwd_valid <= 1'b0;
         fwd_bin   <= 8'd0;
         fwd_data  <= '0;
         scan_cnt  <= '0;
         scan_v    <= 1'b0;
         scan_addr <= 8'd0;
         cdf       <= '0;
         done_r    <= 1'b0;
      end else begin
         done_r    <= 1'b0;
         s1_valid  <= transfer;
         if (transfer) begin
            s1_bin <= pix_data;
         end
         fwd_valid <= s1_valid;
         fwd_bin   <= s1_bin;
         fwd_data  <= acc_wdata;

         case (state)
            INIT_CLR: begin
               if (clr_cnt[8]) begin
                  clr_we <= 1'b0;
                  state  <= IDLE;
               end else begin
                  clr_we   <= 1'b1;
                  clr_addr <= clr_cnt[7:0];
                  clr_cnt  <= clr_cnt + 1'b1;
               end
            end

            IDLE: begin
               if (start) begin
                  pix_cnt <= '0;
                  state   <= ACCUM;
               end
            end

            ACCUM: begin
               if (transfer) begin
                  pix_cnt <= pix_cnt + 1'b1;
                  if (pix_cnt == FRAME_LAST) begin
                     state <= DRAIN;
                  end
               end
            end

            DRAIN: begin
               scan_cnt <= '0;
               cdf      <= '0;
               state    <= SCAN;
            end

            SCAN: begin
               if (scan_v) begin
                  cdf <= cdf_next;
               end
               if (scan_cnt[8]) begin
                  scan_v <= 1'b0;
                  done_r <= 1'b1;
                  state  <= IDLE;
               end else begin
                  scan_v    <= 1'b1;
                  scan_addr <= scan_cnt[7:0];
                  scan_cnt  <= scan_cnt + 1'b1;
               end
            end

            default: begin
               state <= INIT_CLR;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hist_eq_controller.sv
// tb_hist_eq_controller
//
// Bench for hist_eq_controller at LOG2_PIX=4 / BIN_W=5 (16-pixel frames).
// The bench models the histogram memory (synchronous read, read-before-write
// on an address collision, junk-filled while reset is held). Expected LUT
// entries are queued per frame from hand-derived formulas and a monitor pops
// and compares them whenever the DUT strobes lut_we.

module tb_hist_eq_controller;

   localparam int LOG2_PIX = 4;
   localparam int BIN_W    = 5;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             start = 1'b0;
   logic             pix_valid = 1'b0;
   logic [7:0]       pix_data = 8'd0;
   logic             pix_ready;
   logic [7:0]       mem_rd_addr;
   logic [BIN_W-1:0] mem_rdata;
   logic             mem_we;
   logic [7:0]       mem_wr_addr;
   logic [BIN_W-1:0] mem_wdata;
   logic             lut_we;
   logic [7:0]       lut_addr;
   logic [7:0]       lut_data;
   logic             busy;
   logic             done;

   typedef struct {
      logic [7:0] addr;
      logic [7:0] data;
   } lut_exp_t;

   lut_exp_t exp_q[$];
   int       vectors = 0;
   int       miscompares = 0;
   logic     done_prev = 1'b0;
   logic [BIN_W-1:0] mem [256];

   always #5 clk = ~clk;

   hist_eq_controller #(
      .LOG2_PIX (LOG2_PIX),
      .BIN_W    (BIN_W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .pix_valid   (pix_valid),
      .pix_data    (pix_data),
      .pix_ready   (pix_ready),
      .mem_rd_addr (mem_rd_addr),
      .mem_rdata   (mem_rdata),
      .mem_we      (mem_we),
      .mem_wr_addr (mem_wr_addr),
      .mem_wdata   (mem_wdata),
      .lut_we      (lut_we),
      .lut_addr    (lut_addr),
      .lut_data    (lut_data),
      .busy        (busy),
      .done        (done)
   );

   // Histogram memory model. Filling it with junk during reset means any bin
   // the controller fails to clear shows up as a wrong LUT entry.
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 256; i++) begin
            mem[i] <= BIN_W'(i * 7 + 3);
         end
      end else if (mem_we) begin
         mem[mem_wr_addr] <= mem_wdata;
      end
      mem_rdata <= mem[mem_rd_addr];
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Scoreboard monitor: every LUT strobe consumes one queued expectation.
   always @(negedge clk) begin
      lut_exp_t e;
      if (!reset && lut_we) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL lut_unexpected: got entry %0d = %0d, expected no entry", lut_addr, lut_data);
         end else begin
            e = exp_q.pop_front();
            checkOutput("lut_addr", int'(lut_addr), int'(e.addr));
            checkOutput("lut_data", int'(lut_data), int'(e.data));
         end
      end
   end

   // done must never stay high for two consecutive cycles.
   always @(negedge clk) begin
      if (done) begin
         checkOutput("done_single", int'(done_prev), 0);
      end
      done_prev <= done;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic pulseStart;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Expected LUT for each directed frame, derived by hand from the pixel mix.
   task automatic pushFrame(input int kind);
      lut_exp_t e;
      int v;
      for (int k = 0; k < 256; k++) begin
         case (kind)
            0:       v = (k < 7) ? 0 : 255;                        // 16 x pixel 7
            1:       v = (k <= 15) ? (((k + 1) * 255) >> 4) : 255; // pixels 0..15
            2:       v = (k < 200) ? 0 : 255;                      // 16 x pixel 200
            3:       v = (k < 150) ? 0 : 255;                      // 16 x pixel 150
            default: v = (k < 10) ? 0 : ((k < 20) ? 127 : 255);    // 8 x 10, 8 x 20
         endcase
         e.addr = 8'(k);
         e.data = 8'(v);
         exp_q.push_back(e);
      end
   endtask

   // One pixel after `gap` idle cycles; waits (bounded) for pix_ready.
   task automatic applyStimulus(input logic [7:0] value, input int gap);
      logic ok;
      ok = 1'b0;
      pix_valid = 1'b0;
      repeat (gap) tick();
      pix_valid = 1'b1;
      pix_data  = value;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (pix_ready) ok = 1'b1;
         tick();
      end
      pix_valid = 1'b0;
      if (!ok) checkOutput("pix_ready_timeout", 0, 1);
   endtask

   // Called in the cycle right after the frame's final transfer (DRAIN).
   // Checks the final forwarded write, then the done latency: 257 scan
   // cycles follow DRAIN, and done appears in the cycle after those.
   task automatic finishFrame(input int last_bin, input int last_count, input int pulse_at);
      int n;
      @(negedge clk);
      checkOutput("pix_ready_after_frame", int'(pix_ready), 0);
      checkOutput("final_we", int'(mem_we), 1);
      checkOutput("final_wr_addr", int'(mem_wr_addr), last_bin);
      checkOutput("final_wdata", int'(mem_wdata), last_count);
      n = -1;
      for (int i = 1; i <= 400; i++) begin
         @(negedge clk);
         start = (i == pulse_at);
         if (done) begin
            n = i;
            break;
         end
      end
      start = 1'b0;
      checkOutput("done_latency", n, 258);
      checkOutput("lut_entries_left", exp_q.size(), 0);
      @(negedge clk);
      checkOutput("done_cleared", int'(done), 0);
      checkOutput("busy_after_done", int'(busy), 0);
   endtask

   task automatic checkResetValues;
      checkOutput("rst_pix_ready", int'(pix_ready), 0);
      checkOutput("rst_mem_we", int'(mem_we), 0);
      checkOutput("rst_lut_we", int'(lut_we), 0);
      checkOutput("rst_done", int'(done), 0);
      checkOutput("rst_busy", int'(busy), 1);
      checkOutput("rst_mem_rd_addr", int'(mem_rd_addr), 0);
      checkOutput("rst_mem_wr_addr", int'(mem_wr_addr), 0);
      checkOutput("rst_mem_wdata", int'(mem_wdata), 0);
      checkOutput("rst_lut_addr", int'(lut_addr), 0);
      checkOutput("rst_lut_data", int'(lut_data), 0);
   endtask

   initial begin
      int   wr_cnt;
      int   nonzero;
      int   lut_cnt;
      int   first_idle;
      int   covered;
      logic seen [256];
      logic found;

      // Reset values, then the power-up clear sweep.
      repeat (3) tick();
      @(negedge clk);
      checkResetValues();
      tick();
      reset = 1'b0;

      wr_cnt = 0;
      nonzero = 0;
      lut_cnt = 0;
      first_idle = -1;
      for (int i = 0; i < 256; i++) seen[i] = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (mem_we) begin
            wr_cnt++;
            seen[mem_wr_addr] = 1'b1;
            if (mem_wdata != '0) nonzero++;
         end
         if (lut_we) lut_cnt++;
         if (!busy && first_idle < 0) first_idle = i;
      end
      covered = 0;
      for (int i = 0; i < 256; i++) if (seen[i]) covered++;
      checkOutput("clr_write_count", wr_cnt, 256);
      checkOutput("clr_addr_coverage", covered, 256);
      checkOutput("clr_nonzero_data", nonzero, 0);
      checkOutput("clr_lut_strobes", lut_cnt, 0);
      checkOutput("clr_busy_fall_cycle", first_idle, 257);
      tick();

      // Frame 1: sixteen back-to-back 7s, every write after the first forwarded.
      $display("[TB] frame 1: back-to-back equal pixels");
      pushFrame(0);
      pulseStart();
      for (int k = 0; k < 16; k++) applyStimulus(8'd7, 0);
      finishFrame(7, 16, 0);

      // Frame 2: pixels 0..15 with irregular gaps; start pulsed mid-ACCUM
      // and again mid-SCAN, both of which must be ignored.
      $display("[TB] frame 2: ramp with gaps, stray start pulses");
      pushFrame(1);
      pulseStart();
      for (int k = 0; k < 16; k++) begin
         if (k == 5) pulseStart();
         applyStimulus(8'(k), int'($urandom_range(0, 3)));
      end
      finishFrame(15, 1, 50);

      // Frame 3: no residue from frame 2 may survive the scan clear.
      $display("[TB] frame 3: all pixels 200");
      pushFrame(2);
      pulseStart();
      for (int k = 0; k < 16; k++) applyStimulus(8'd200, 0);
      finishFrame(200, 16, 0);

      // Frame 4: reset in the middle of the scan.
      $display("[TB] frame 4: reset during scan");
      pushFrame(3);
      pulseStart();
      for (int k = 0; k < 16; k++) applyStimulus(8'd150, 0);
      found = 1'b0;
      for (int i = 0; i < 400 && !found; i++) begin
         @(negedge clk);
         if (lut_we && lut_addr == 8'd100) found = 1'b1;
      end
      checkOutput("reached_scan_100", int'(found), 1);
      #1;
      reset = 1'b1;
      exp_q.delete();
      #1;
      checkResetValues();
      tick();
      tick();
      reset = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 400 && !found; i++) begin
         @(negedge clk);
         start = (i == 20);
         if (!busy) found = 1'b1;
      end
      start = 1'b0;
      checkOutput("reclear_finished", int'(found), 1);
      @(negedge clk);
      checkOutput("start_in_clear_ignored", int'(busy), 0);
      tick();

      // Frame 5: correct LUT after the re-clear (gaps of one cycle exercise
      // the non-forwarded path on a repeated bin).
      $display("[TB] frame 5: after reset recovery");
      pushFrame(4);
      pulseStart();
      for (int k = 0; k < 8; k++) applyStimulus(8'd10, k % 2);
      for (int k = 0; k < 8; k++) applyStimulus(8'd20, 0);
      finishFrame(20, 8, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
